teng_step_engine: RTL and testbench

- Parametrised, synthesizable successor to the fixed 4-bit TENG stimulus bench.
- Accepts a stream of displacement samples X and advances a discrete-time TENG-plus-load-capacitor model one step per sample.
- Outputs signed charge Q, terminal voltage Vteng and capacitor current Icap in fixed point.
- Uses one shared multiplier sequenced by an FSM; sits between a displacement stimulus source and the harvester/load logic.

---
 rtl/teng_step_engine.sv | 167 ++++++++++++++++
 tb/tb_teng_step_engine.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/teng_step_engine.sv
// Discrete-time TENG + load-capacitor step engine: one model step per displacement sample,
// sequenced over a single shared multiplier. Optional half-wave rectifier: TENG_RECTIFIER_EN.
module teng_step_engine #(
    parameter int XW   = 8,
    parameter int QW   = 16,
    parameter int VW   = 16,
    parameter int KW   = 8,
    parameter int K_OC = 16,
    parameter int K_C  = 8,
    parameter int K_G  = 4,
    parameter int FRAC = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 x_valid,
    input  logic [XW-1:0]        x_in,
    output logic                 x_ready,
    input  logic                 q_clear,
    output logic                 out_valid,
    output logic signed [QW-1:0] q_out,
    output logic signed [VW-1:0] vteng_out,
    output logic signed [QW-1:0] icap_out,
    output logic [15:0]          step_cnt
);

    localparam int MW_QV = (QW > VW) ? QW : VW;
    localparam int MW    = (MW_QV > XW + 1) ? MW_QV : XW + 1;
    localparam int PW    = MW + KW + 1;
    localparam int SW    = PW + 1;

    // Gains are unsigned; one extra zero MSB lets them feed the signed multiplier.
    localparam logic signed [KW:0] KOC_S = (KW + 1)'(K_OC);
    localparam logic signed [KW:0] KC_S  = (KW + 1)'(K_C);
    localparam logic signed [KW:0] KG_S  = (KW + 1)'(K_G);

    localparam logic signed [SW-1:0] V_MAX = SW'({1'b0, {(VW - 1){1'b1}}});
    localparam logic signed [SW-1:0] V_MIN = ~V_MAX;
    localparam logic signed [SW-1:0] Q_MAX = SW'({1'b0, {(QW - 1){1'b1}}});
    localparam logic signed [SW-1:0] Q_MIN = ~Q_MAX;

    typedef enum logic [2:0] {IDLE, MX, MQ, MI, UPD} state_t;

    function automatic logic signed [VW-1:0] sat_v(input logic signed [SW-1:0] a);
        if (a > V_MAX)      return V_MAX[VW-1:0];
        else if (a < V_MIN) return V_MIN[VW-1:0];
        else                return a[VW-1:0];
    endfunction

    function automatic logic signed [QW-1:0] sat_q(input logic signed [SW-1:0] a);
        if (a > Q_MAX)      return Q_MAX[QW-1:0];
        else if (a < Q_MIN) return Q_MIN[QW-1:0];
        else                return a[QW-1:0];
    endfunction

    state_t                 state_q, state_d;
    logic [XW-1:0]          x_q, x_d;
    logic signed [PW-1:0]   voc_q, voc_d;
    logic signed [VW-1:0]   vstep_q, vstep_d;
    logic signed [QW-1:0]   q_q, q_d, icap_q, icap_d;
    logic signed [VW-1:0]   vteng_q, vteng_d;
    logic [15:0]            cnt_q, cnt_d;
    logic                   ov_q, ov_d;

    logic signed [MW-1:0]   mul_a;
    logic signed [KW:0]     mul_b;
    logic signed [PW-1:0]   mul_p, mul_sh;
    logic signed [QW-1:0]   i_raw, i_val;

    // Single shared multiplier; the operand pair is chosen by the current step phase.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            MX:      begin mul_a = MW'(x_q);     mul_b = KOC_S; end
            MQ:      begin mul_a = MW'(q_q);     mul_b = KC_S;  end
            MI:      begin mul_a = MW'(vstep_q); mul_b = KG_S;  end
            default: ;
        endcase
        mul_p  = PW'(mul_a) * PW'(mul_b);
        mul_sh = mul_p >>> FRAC;
        i_raw  = sat_q(SW'(mul_sh));
`ifdef TENG_RECTIFIER_EN
        i_val  = i_raw[QW-1] ? '0 : i_raw;
`else
        i_val  = i_raw;
`endif
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        voc_d   = voc_q;
        vstep_d = vstep_q;
        q_d     = q_q;
        vteng_d = vteng_q;
        icap_d  = icap_q;
        cnt_d   = cnt_q;
        ov_d    = 1'b0;
        if (q_clear) begin
            state_d = IDLE;
            q_d     = '0;
            vteng_d = '0;
            icap_d  = '0;
        end else begin
            case (state_q)
                IDLE: if (x_valid) begin
                    x_d     = x_in;
                    state_d = MX;
                end
                MX: begin
                    voc_d   = mul_sh;
                    state_d = MQ;
                end
                MQ: begin
                    vstep_d = sat_v(SW'(voc_q) - SW'(mul_sh));
                    state_d = MI;
                end
                // Results are registered here so they are visible while out_valid is high in UPD.
                MI: begin
                    q_d     = sat_q(SW'(q_q) + SW'(i_val));
                    vteng_d = vstep_q;
                    icap_d  = i_val;
                    cnt_d   = cnt_q + 16'd1;
                    ov_d    = 1'b1;
                    state_d = UPD;
                end
                UPD:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            voc_q   <= '0;
            vstep_q <= '0;
            q_q     <= '0;
            vteng_q <= '0;
            icap_q  <= '0;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            x_q     <= x_d;
            voc_q   <= voc_d;
            vstep_q <= vstep_d;
            q_q     <= q_d;
            vteng_q <= vteng_d;
            icap_q  <= icap_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
        end
    end

    // Ready is gated by rst so it reads 0 throughout reset, and by q_clear so a clear wins.
    assign x_ready   = (state_q == IDLE) && !rst && !q_clear;
    assign out_valid = ov_q;
    assign q_out     = q_q;
    assign vteng_out = vteng_q;
    assign icap_out  = icap_q;
    assign step_cnt  = cnt_q;

endmodule

// File: tb/tb_teng_step_engine.sv
// Self-checking bench for teng_step_engine: default build plus a QW=8 instance sharing the inputs,
// both checked against a floor/saturate arithmetic model of the TENG step equations.
module tb_teng_step_engine;

    localparam int K_OC = 16, K_C = 8, K_G = 4, FRAC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        x_valid = 1'b0;
    logic [7:0]  x_in = '0;
    logic        q_clear = 1'b0;

    logic               x_ready, out_valid;
    logic signed [15:0] q_out, vteng_out, icap_out;
    logic [15:0]        step_cnt;
    logic               x_ready8, out_valid8;
    logic signed [7:0]  q8, icap8;
    logic signed [15:0] vteng8;
    logic [15:0]        cnt8;

    int n_checks = 0;
    int n_fail   = 0;

    longint m_q16, m_q8, m_v16, m_i16, m_v8, m_i8;
    int     m_cnt;

    teng_step_engine dut (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x_in(x_in), .x_ready(x_ready),
        .q_clear(q_clear), .out_valid(out_valid), .q_out(q_out), .vteng_out(vteng_out),
        .icap_out(icap_out), .step_cnt(step_cnt)
    );

    teng_step_engine #(.QW(8)) dut8 (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x_in(x_in), .x_ready(x_ready8),
        .q_clear(q_clear), .out_valid(out_valid8), .q_out(q8), .vteng_out(vteng8),
        .icap_out(icap8), .step_cnt(cnt8)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic longint sat(input longint a, input int n);
        longint hi, lo;
        hi = (64'sd1 <<< (n - 1)) - 1;
        lo = -(64'sd1 <<< (n - 1));
        return (a > hi) ? hi : ((a < lo) ? lo : a);
    endfunction

    // One TENG step from the physical equations, with >>> on signed longint giving floor.
    task automatic model_eq(input longint x, input longint q, input int qw,
                            output longint v, output longint i, output longint qn);
        longint voc, vq;
        voc = (x * K_OC) >>> FRAC;
        vq  = (q * K_C) >>> FRAC;
        v   = sat(voc - vq, 16);
        i   = sat((v * K_G) >>> FRAC, qw);
`ifdef TENG_RECTIFIER_EN
        if (i < 0) i = 0;
`endif
        qn  = sat(q + i, qw);
    endtask

    task automatic model_update(input longint x);
        longint qn;
        model_eq(x, m_q16, 16, m_v16, m_i16, qn); m_q16 = qn;
        model_eq(x, m_q8, 8, m_v8, m_i8, qn);     m_q8  = qn;
        m_cnt = (m_cnt + 1) % 65536;
    endtask

    task automatic model_reset;
        m_q16 = 0; m_q8 = 0; m_v16 = 0; m_i16 = 0; m_v8 = 0; m_i8 = 0; m_cnt = 0;
    endtask

    task automatic do_reset;
        x_valid = 1'b0; q_clear = 1'b0; rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
    endtask

    // Send one sample, measure handshake-to-out_valid latency, compare both instances.
    task automatic run_step(input logic [7:0] x);
        int n;
        n = 0;
        while (x_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        n_checks++; if (x_ready !== 1'b1) begin n_fail++; $display("FAIL ready_wait: x_ready=%b want 1", x_ready); end
        x_valid = 1'b1; x_in = x;
        @(posedge clk);
        @(negedge clk);
        x_valid = 1'b0; x_in = 8'($urandom);
        n = 1;
        while (out_valid !== 1'b1 && n < 8) begin @(negedge clk); n++; end
        model_update(longint'(x));
        n_checks++; if (n != 4) begin n_fail++; $display("FAIL latency x=%0d: got %0d cycles want 4", x, n); end
        n_checks++; if (out_valid8 !== 1'b1) begin n_fail++; $display("FAIL ov8 x=%0d: got %b want 1", x, out_valid8); end
        n_checks++; if (q_out !== 16'(m_q16)) begin n_fail++; $display("FAIL q16 x=%0d: got %0d want %0d", x, q_out, m_q16); end
        n_checks++; if (vteng_out !== 16'(m_v16)) begin n_fail++; $display("FAIL v16 x=%0d: got %0d want %0d", x, vteng_out, m_v16); end
        n_checks++; if (icap_out !== 16'(m_i16)) begin n_fail++; $display("FAIL i16 x=%0d: got %0d want %0d", x, icap_out, m_i16); end
        n_checks++; if (step_cnt !== 16'(m_cnt)) begin n_fail++; $display("FAIL cnt16: got %0d want %0d", step_cnt, m_cnt); end
        n_checks++; if (q8 !== 8'(m_q8)) begin n_fail++; $display("FAIL q8 x=%0d: got %0d want %0d", x, q8, m_q8); end
        n_checks++; if (vteng8 !== 16'(m_v8)) begin n_fail++; $display("FAIL v8 x=%0d: got %0d want %0d", x, vteng8, m_v8); end
        n_checks++; if (icap8 !== 8'(m_i8)) begin n_fail++; $display("FAIL i8 x=%0d: got %0d want %0d", x, icap8, m_i8); end
        n_checks++; if (cnt8 !== 16'(m_cnt)) begin n_fail++; $display("FAIL cnt8: got %0d want %0d", cnt8, m_cnt); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ov_pulse: got %b want 0", out_valid); end
    endtask

    task automatic test_reset;
        rst = 1'b1; x_valid = 1'b1; x_in = 8'd99;
        @(negedge clk);
        n_checks++; if (x_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", x_ready); end
        n_checks++; if ({out_valid, q_out, vteng_out, icap_out, step_cnt} !== '0) begin n_fail++; $display("FAIL rst_outputs: q=%0d v=%0d i=%0d cnt=%0d ov=%b want all 0", q_out, vteng_out, icap_out, step_cnt, out_valid); end
        x_valid = 1'b0;
        do_reset();
        n_checks++; if (x_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", x_ready); end
    endtask

    task automatic test_plan_sequence;
        int xs[4]  = '{20, 70, 20, 0};
        int ev[4]  = '{20, 68, 9, -12};
`ifdef TENG_RECTIFIER_EN
        int ei[4]  = '{5, 17, 2, 0};
        int eq[4]  = '{5, 22, 24, 24};
`else
        int ei[4]  = '{5, 17, 2, -3};
        int eq[4]  = '{5, 22, 24, 21};
`endif
        do_reset();
        for (int k = 0; k < 4; k++) begin
            run_step(8'(xs[k]));
            n_checks++; if (vteng_out !== 16'(ev[k])) begin n_fail++; $display("FAIL plan_v%0d: got %0d want %0d", k, vteng_out, ev[k]); end
            n_checks++; if (icap_out !== 16'(ei[k])) begin n_fail++; $display("FAIL plan_i%0d: got %0d want %0d", k, icap_out, ei[k]); end
            n_checks++; if (q_out !== 16'(eq[k])) begin n_fail++; $display("FAIL plan_q%0d: got %0d want %0d", k, q_out, eq[k]); end
        end
    endtask

    task automatic test_saturation;
        int eq[3] = '{63, 119, 127};
        int ei[3] = '{63, 56, 49};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            run_step(8'd255);
            n_checks++; if (q8 !== 8'(eq[k])) begin n_fail++; $display("FAIL sat_q8_%0d: got %0d want %0d", k, q8, eq[k]); end
            n_checks++; if (icap8 !== 8'(ei[k])) begin n_fail++; $display("FAIL sat_i8_%0d: got %0d want %0d", k, icap8, ei[k]); end
        end
    endtask

    task automatic test_clear;
        do_reset();
        run_step(8'd20);
        run_step(8'd70);
        x_valid = 1'b1; x_in = 8'd20;
        @(posedge clk);
        @(negedge clk);                      // MX
        x_valid = 1'b0;
        @(negedge clk);                      // MQ
        q_clear = 1'b1;
        @(negedge clk);
        q_clear = 1'b0;
        m_q16 = 0; m_q8 = 0;
        #1;
        n_checks++; if ({out_valid, q_out, vteng_out, icap_out} !== '0) begin n_fail++; $display("FAIL clear_outputs: q=%0d v=%0d i=%0d ov=%b want 0", q_out, vteng_out, icap_out, out_valid); end
        n_checks++; if (step_cnt !== 16'(m_cnt)) begin n_fail++; $display("FAIL clear_cnt: got %0d want %0d", step_cnt, m_cnt); end
        n_checks++; if (x_ready !== 1'b1) begin n_fail++; $display("FAIL clear_ready: got %b want 1", x_ready); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_no_ov cycle %0d: got %b want 0", k, out_valid); end
        end
        x_valid = 1'b1; q_clear = 1'b1; x_in = 8'd77;
        #1;
        n_checks++; if (x_ready !== 1'b0) begin n_fail++; $display("FAIL clear_vs_valid_ready: got %b want 0", x_ready); end
        @(negedge clk);
        x_valid = 1'b0; q_clear = 1'b0;
        #1;
        n_checks++; if (x_ready !== 1'b1) begin n_fail++; $display("FAIL clear_vs_valid_not_taken: x_ready=%b want 1", x_ready); end
        run_step(8'd20);
        n_checks++; if (q_out !== 16'sd5) begin n_fail++; $display("FAIL clear_then_step: got %0d want 5", q_out); end
    endtask

    task automatic test_async_reset;
        do_reset();
        run_step(8'd20);
        x_valid = 1'b1; x_in = 8'd70;
        @(posedge clk);
        @(negedge clk);                      // MX
        x_valid = 1'b0;
        repeat (2) @(negedge clk);           // MQ, then MI
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({out_valid, q_out, vteng_out, icap_out, step_cnt} !== '0) begin n_fail++; $display("FAIL async_rst16: q=%0d v=%0d i=%0d cnt=%0d want 0", q_out, vteng_out, icap_out, step_cnt); end
        n_checks++; if ({out_valid8, q8, vteng8, icap8, cnt8} !== '0) begin n_fail++; $display("FAIL async_rst8: q=%0d v=%0d i=%0d cnt=%0d want 0", q8, vteng8, icap8, cnt8); end
        n_checks++; if (x_ready !== 1'b0) begin n_fail++; $display("FAIL async_rst_ready: got %b want 0", x_ready); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++; if (x_ready !== 1'b1) begin n_fail++; $display("FAIL async_release_ready: got %b want 1", x_ready); end
        run_step(8'd20);
        n_checks++; if (q_out !== 16'sd5) begin n_fail++; $display("FAIL async_then_step: got %0d want 5", q_out); end
    endtask

    task automatic test_random;
        do_reset();
        for (int k = 0; k < 30; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_step(8'($urandom_range(0, 255)));
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] pend[$];
        logic [7:0] xa;
        int outs;
        outs = 0;
        x_valid = 1'b1;
        for (int k = 0; k < 25; k++) begin
            n_checks++; if (out_valid !== ((k % 5) == 4)) begin n_fail++; $display("FAIL b2b_ov k=%0d: got %b want %b", k, out_valid, (k % 5) == 4); end
            if (out_valid === 1'b1 && pend.size() > 0) begin
                xa = pend.pop_front();
                model_update(longint'(xa));
                outs++;
                n_checks++; if (q_out !== 16'(m_q16)) begin n_fail++; $display("FAIL b2b_q16 x=%0d: got %0d want %0d", xa, q_out, m_q16); end
                n_checks++; if (q8 !== 8'(m_q8)) begin n_fail++; $display("FAIL b2b_q8 x=%0d: got %0d want %0d", xa, q8, m_q8); end
                n_checks++; if (step_cnt !== 16'(m_cnt)) begin n_fail++; $display("FAIL b2b_cnt: got %0d want %0d", step_cnt, m_cnt); end
            end
            n_checks++; if (x_ready !== ((k % 5) == 0)) begin n_fail++; $display("FAIL b2b_ready k=%0d: got %b want %b", k, x_ready, (k % 5) == 0); end
            x_in = 8'($urandom);
            if (x_ready === 1'b1) pend.push_back(x_in);
            @(negedge clk);
        end
        x_valid = 1'b0;
        n_checks++; if (outs != 5 || pend.size() != 0) begin n_fail++; $display("FAIL b2b_count: got %0d results, %0d pending; want 5, 0", outs, pend.size()); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_plan_sequence();
        test_saturation();
        test_clear();
        test_async_reset();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
